// File: rtl/dm_timer_pkg.sv
// Shared constants for the dm_timer peripheral: register offsets, CTRL bit
// positions and the Bit_S access-size encodings also used by DMEM.
package dm_timer_pkg;

   localparam int TMR_CTRL     = 'h00;
   localparam int TMR_PRESCALE = 'h04;
   localparam int TMR_COUNT    = 'h08;
   localparam int TMR_COMPARE  = 'h0C;
   localparam int TMR_STATUS   = 'h10;
   localparam int TMR_CYCLE    = 'h14;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;
   localparam int CTRL_W           = 3;

   localparam logic [1:0] BS_WORD = 2'b00;
   localparam logic [1:0] BS_HALF = 2'b01;
   localparam logic [1:0] BS_BYTE = 2'b10;

endpackage

// File: rtl/dm_lane_merge.sv
// Combinational byte-lane helper for the data-memory bus: merges sub-word
// writes into an existing word and extracts right-justified sub-word reads.
module dm_lane_merge
   import dm_timer_pkg::*;
(
   input  logic [1:0]  bit_s,
   input  logic [1:0]  byte_off,
   input  logic [31:0] old_word,
   input  logic [31:0] wr_data,
   input  logic [31:0] rd_word,
   output logic [31:0] merged,
   output logic [31:0] rd_data
);

   // Halfword accesses only look at byte_off[1], so a misaligned halfword
   // silently lands on the enclosing aligned lane.
   always_comb begin
      merged  = old_word;
      rd_data = rd_word;
      case (bit_s)
         BS_HALF: begin
            if (byte_off[1]) begin
               merged[31:16] = wr_data[15:0];
               rd_data       = {16'b0, rd_word[31:16]};
            end else begin
               merged[15:0]  = wr_data[15:0];
               rd_data       = {16'b0, rd_word[15:0]};
            end
         end
         BS_BYTE: begin
            merged[{byte_off, 3'b000} +: 8] = wr_data[7:0];
            rd_data = {24'b0, rd_word[{byte_off, 3'b000} +: 8]};
         end
         BS_WORD: merged = wr_data;
         default: merged = wr_data;
      endcase
   end

endmodule

// File: rtl/dm_timer.sv
// Memory-mapped prescaled timer on the CPU data-memory port.
// Define DM_TIMER_CYCLE_EN to add the read-only free-running CYCLE counter.
module dm_timer
   import dm_timer_pkg::*;
#(
   parameter int ADDR_W     = 11,
   parameter int PRESCALE_W = 16
)(
   input  logic              clk_in,
   input  logic              reset,
   input  logic              CS,
   input  logic              DM_R,
   input  logic              DM_W,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [31:0]       Data_In,
   input  logic [1:0]        Bit_S,
   output logic [31:0]       Data_Out,
   output logic              irq
);

   logic [ADDR_W-3:0]     word_addr;
   logic                  sel_ctrl, sel_prescale, sel_count;
   logic                  sel_compare, sel_status, sel_cycle;
   logic                  wr_en, tick, hit;
   logic [CTRL_W-1:0]     ctrl;
   logic [PRESCALE_W-1:0] prescale, pcnt;
   logic [31:0]           count, compare;
   logic                  match;
   logic [31:0]           cycle_rd, rd_word, old_word, merged, rd_data;

   assign word_addr    = Addr[ADDR_W-1:2];
   assign sel_ctrl     = (word_addr == (ADDR_W-2)'(TMR_CTRL     >> 2));
   assign sel_prescale = (word_addr == (ADDR_W-2)'(TMR_PRESCALE >> 2));
   assign sel_count    = (word_addr == (ADDR_W-2)'(TMR_COUNT    >> 2));
   assign sel_compare  = (word_addr == (ADDR_W-2)'(TMR_COMPARE  >> 2));
   assign sel_status   = (word_addr == (ADDR_W-2)'(TMR_STATUS   >> 2));
   assign sel_cycle    = (word_addr == (ADDR_W-2)'(TMR_CYCLE    >> 2));
   assign wr_en        = CS & DM_W;

`ifdef DM_TIMER_CYCLE_EN
   logic [31:0] cycle_cnt;

   always_ff @(posedge clk_in) begin
      if (reset) cycle_cnt <= '0;
      else       cycle_cnt <= cycle_cnt + 32'd1;
   end

   assign cycle_rd = cycle_cnt;
`else
   assign cycle_rd = '0;
`endif

   always_comb begin
      rd_word = '0;
      if (sel_ctrl)     rd_word = {{(32-CTRL_W){1'b0}}, ctrl};
      if (sel_prescale) rd_word = 32'(prescale);
      if (sel_count)    rd_word = count;
      if (sel_compare)  rd_word = compare;
      if (sel_status)   rd_word = {31'b0, match};
      if (sel_cycle)    rd_word = cycle_rd;
   end

   // STATUS merges against zero so merged[0] is set only when the written lane carries a 1.
   assign old_word = sel_status ? '0 : rd_word;

   dm_lane_merge u_lane_merge (
      .bit_s    (Bit_S),
      .byte_off (Addr[1:0]),
      .old_word (old_word),
      .wr_data  (Data_In),
      .rd_word  (rd_word),
      .merged   (merged),
      .rd_data  (rd_data)
   );

   assign Data_Out = (CS & DM_R) ? rd_data : '0;

   assign tick = ctrl[CTRL_EN] && (pcnt == prescale);
   assign hit  = tick && (count == compare);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         ctrl     <= '0;
         prescale <= '0;
         pcnt     <= '0;
      end else begin
         if (wr_en && sel_ctrl)     ctrl     <= merged[CTRL_W-1:0];
         if (wr_en && sel_prescale) prescale <= merged[PRESCALE_W-1:0];
         if ((wr_en && (sel_ctrl || sel_prescale)) || tick || !ctrl[CTRL_EN])
            pcnt <= '0;
         else
            pcnt <= pcnt + PRESCALE_W'(1);
      end
   end

   // Bus writes to COUNT override the tick; a hardware match overrides a W1C.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         count   <= '0;
         compare <= '0;
         match   <= 1'b0;
         irq     <= 1'b0;
      end else begin
         irq <= match & ctrl[CTRL_IRQ_EN];
         if (wr_en && sel_compare) compare <= merged;
         if (wr_en && sel_count)
            count <= merged;
         else if (tick)
            count <= (hit && ctrl[CTRL_AUTO_RELOAD]) ? '0 : count + 32'd1;
         if (hit)
            match <= 1'b1;
         else if (wr_en && sel_status && merged[0])
            match <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dm_timer.sv
// Self-checking bench for dm_timer: directed scenarios plus a random bus phase,
// every cycle compared against a byte-oriented behavioural model.
module tb_dm_timer;
   import dm_timer_pkg::*;

   logic        clk_in = 1'b0;
   logic        reset, CS, DM_R, DM_W;
   logic [10:0] Addr;
   logic [31:0] Data_In;
   logic [1:0]  Bit_S;
   logic [31:0] Data_Out;
   logic        irq;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [2:0]  m_ctrl;
   logic [15:0] m_pre;
   int          m_pcnt;
   logic [31:0] m_count, m_cmp, m_cycle;
   logic        m_match, m_irq;

   dm_timer dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .CS       (CS),
      .DM_R     (DM_R),
      .DM_W     (DM_W),
      .Addr     (Addr),
      .Data_In  (Data_In),
      .Bit_S    (Bit_S),
      .Data_Out (Data_Out),
      .irq      (irq)
   );

   always #5 clk_in = ~clk_in;

   // Number of bytes touched and first byte lane for an access
   function automatic void mdlLanes(input logic [1:0] bs, input logic [1:0] a,
                                    output int first, output int n);
      if (bs == 2'b01)      begin first = 2 * int'(a[1]); n = 2; end
      else if (bs == 2'b10) begin first = int'(a);        n = 1; end
      else                  begin first = 0;              n = 4; end
   endfunction

   function automatic logic [31:0] mdlMerge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] bs, input logic [1:0] a);
      int first, n;
      logic [31:0] r;
      r = old;
      mdlLanes(bs, a, first, n);
      for (int k = 0; k < n; k++) r[8*(first+k) +: 8] = d[8*k +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mdlExtract(input logic [31:0] w, input logic [1:0] bs,
                                              input logic [1:0] a);
      int first, n;
      mdlLanes(bs, a, first, n);
      if (n == 4) return w;
      return (w >> (8*first)) & ((32'h1 << (8*n)) - 32'h1);
   endfunction

   function automatic logic [31:0] mdlRead(input logic [10:0] a);
      case (int'({a[10:2], 2'b00}))
         'h00: return {29'b0, m_ctrl};
         'h04: return {16'b0, m_pre};
         'h08: return m_count;
         'h0C: return m_cmp;
         'h10: return {31'b0, m_match};
`ifdef DM_TIMER_CYCLE_EN
         'h14: return m_cycle;
`endif
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model by one rising edge
   task automatic mdlStep(input logic rst, input logic cs, input logic wr, input logic [10:0] a,
                          input logic [31:0] d, input logic [1:0] bs);
      bit tick, hit, en;
      logic [31:0] w;
      if (rst) begin
         m_ctrl = '0; m_pre = '0; m_pcnt = 0; m_count = '0; m_cmp = '0;
         m_cycle = '0; m_match = 1'b0; m_irq = 1'b0;
         return;
      end
      en   = m_ctrl[0];
      tick = en && (m_pcnt == int'(m_pre));
      hit  = tick && (m_count == m_cmp);
      m_cycle = m_cycle + 1;
      m_irq   = m_match && m_ctrl[2];
      if (hit)  m_match = 1'b1;
      if (tick) m_count = (hit && m_ctrl[1]) ? 32'h0 : m_count + 1;
      m_pcnt = (en && !tick) ? m_pcnt + 1 : 0;
      if (cs && wr) begin
         case (int'({a[10:2], 2'b00}))
            'h00: begin w = mdlMerge({29'b0, m_ctrl}, d, bs, a[1:0]); m_ctrl = w[2:0]; m_pcnt = 0; end
            'h04: begin w = mdlMerge({16'b0, m_pre}, d, bs, a[1:0]); m_pre = w[15:0]; m_pcnt = 0; end
            'h08: m_count = mdlMerge(m_count, d, bs, a[1:0]);
            'h0C: m_cmp   = mdlMerge(m_cmp, d, bs, a[1:0]);
            'h10: begin
               w = mdlMerge(32'h0, d, bs, a[1:0]);
               if (!hit && w[0]) m_match = 1'b0;
            end
            default: ;
         endcase
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, check combinational read, clock, check irq
   task automatic applyStimulus(input logic rst, input logic cs, input logic rd, input logic wr,
                                input logic [10:0] a, input logic [31:0] d, input logic [1:0] bs,
                                output logic [31:0] obs);
      reset = rst; CS = cs; DM_R = rd; DM_W = wr; Addr = a; Data_In = d; Bit_S = bs;
      #1;
      obs = Data_Out;
      checkOutput("data_out", Data_Out, (cs && rd) ? mdlExtract(mdlRead(a), bs, a[1:0]) : 32'h0);
      @(posedge clk_in);
      mdlStep(rst, cs, wr, a, d, bs);
      #1;
      checkOutput("irq", {31'b0, irq}, {31'b0, m_irq});
   endtask

   task automatic busWrite(input logic [10:0] a, input logic [31:0] d, input logic [1:0] bs);
      logic [31:0] obs;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, a, d, bs, obs);
   endtask

   task automatic busRead(input logic [10:0] a, input logic [1:0] bs, output logic [31:0] obs);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0, bs, obs);
   endtask

   task automatic idle(input int n);
      logic [31:0] obs;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 32'h0, BS_WORD, obs);
   endtask

   initial begin
      logic [31:0] obs, first_rd;
      logic [10:0] ra;
      logic [31:0] rdat;
      int sel;

      $display("[TB] reset and register defaults");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 11'h0, 32'h0, BS_WORD, obs);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 11'h0, 32'h7, BS_WORD, obs);
      for (int off = 0; off <= 'h14; off += 4) begin
         busRead(11'(off), BS_WORD, obs);
         checkOutput("reset_read", obs, 32'h0);
      end
      checkOutput("reset_irq", {31'b0, irq}, 32'h0);
      busWrite(11'h40, 32'hDEADBEEF, BS_WORD);
      busRead(11'h40, BS_WORD, obs);
      checkOutput("unmapped_read", obs, 32'h0);

      $display("[TB] auto-reload match and irq");
      busWrite(11'h04, 32'h0, BS_WORD);
      busWrite(11'h0C, 32'h5, BS_WORD);
      busWrite(11'h00, 32'h7, BS_WORD);
      for (int k = 0; k <= 6; k++) begin
         busRead(11'h08, BS_WORD, obs);
         checkOutput("count_run", obs, (k == 6) ? 32'h0 : 32'(k));
      end
      checkOutput("irq_set", {31'b0, irq}, 32'h1);
      busWrite(11'h00, 32'h4, BS_WORD);
      busWrite(11'h10, 32'h1, BS_WORD);
      idle(1);
      checkOutput("irq_clear", {31'b0, irq}, 32'h0);
      busRead(11'h10, BS_WORD, obs);
      checkOutput("match_clear", obs, 32'h0);

      $display("[TB] prescale and enable freeze");
      busWrite(11'h04, 32'h3, BS_WORD);
      busWrite(11'h08, 32'h0, BS_WORD);
      busWrite(11'h00, 32'h1, BS_WORD);
      for (int k = 0; k < 12; k++) begin
         busRead(11'h08, BS_WORD, obs);
         checkOutput("count_prescale", obs, 32'(k / 4));
      end
      idle(2);
      busWrite(11'h00, 32'h0, BS_WORD);
      idle(5);
      busRead(11'h08, BS_WORD, obs);
      checkOutput("count_frozen", obs, 32'h3);
      busWrite(11'h00, 32'h1, BS_WORD);
      for (int k = 0; k <= 4; k++) begin
         busRead(11'h08, BS_WORD, obs);
         checkOutput("pcnt_restart", obs, (k < 4) ? 32'h3 : 32'h4);
      end
      busWrite(11'h00, 32'h0, BS_WORD);

      $display("[TB] sub-word lane merge");
      busWrite(11'h0C, 32'h0, BS_WORD);
      busWrite(11'h0E, 32'h123456AB, BS_BYTE);
      busWrite(11'h0C, 32'hBEEF1234, BS_HALF);
      busRead(11'h0C, BS_WORD, obs);
      checkOutput("merge_word", obs, 32'h00AB1234);
      busRead(11'h0E, BS_BYTE, obs);
      checkOutput("byte_read", obs, 32'h000000AB);
      busWrite(11'h0D, 32'h00005678, BS_HALF);
      busRead(11'h0C, BS_WORD, obs);
      checkOutput("misaligned_half", obs, 32'h00AB5678);
      busRead(11'h0F, BS_HALF, obs);
      checkOutput("half_read_hi", obs, 32'h000000AB);

      $display("[TB] same-cycle conflicts");
      busWrite(11'h04, 32'h0, BS_WORD);
      busWrite(11'h00, 32'h1, BS_WORD);
      idle(2);
      busWrite(11'h08, 32'h100, BS_WORD);
      busRead(11'h08, BS_WORD, obs);
      checkOutput("count_write_wins", obs, 32'h100);
      busWrite(11'h00, 32'h0, BS_WORD);
      busWrite(11'h10, 32'h1, BS_WORD);
      busWrite(11'h08, 32'h50, BS_WORD);
      busWrite(11'h0C, 32'h50, BS_WORD);
      busWrite(11'h00, 32'h1, BS_WORD);
      busWrite(11'h10, 32'h1, BS_WORD);
      busRead(11'h10, BS_WORD, obs);
      checkOutput("match_beats_w1c", obs, 32'h1);
      busWrite(11'h00, 32'h0, BS_WORD);

      $display("[TB] random bus traffic");
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 7);
         case (sel)
            0: ra = 11'h00;
            1: ra = 11'h04;
            2: ra = 11'h08;
            3: ra = 11'h0C;
            4: ra = 11'h10;
            5: ra = 11'h14;
            6: ra = 11'h40;
            default: ra = 11'($urandom_range(0, 2047));
         endcase
         ra[1:0] = 2'($urandom_range(0, 3));
         rdat = $urandom;
         if (sel == 1) rdat = 32'($urandom_range(0, 3));
         if ((sel == 2 || sel == 3) && $urandom_range(0, 1) == 1) rdat = 32'($urandom_range(0, 12));
         if (sel == 0 && $urandom_range(0, 3) != 0) rdat[0] = 1'b1;
         applyStimulus(($urandom_range(0, 127) == 0), ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ra, rdat, 2'($urandom_range(0, 3)), obs);
      end

`ifdef DM_TIMER_CYCLE_EN
      $display("[TB] cycle counter");
      busRead(11'h14, BS_WORD, first_rd);
      idle(9);
      busRead(11'h14, BS_WORD, obs);
      checkOutput("cycle_delta", obs - first_rd, 32'd10);
`else
      $display("[TB] cycle counter absent");
      first_rd = 32'h0;
      busRead(11'h14, BS_WORD, obs);
      checkOutput("cycle_absent", obs | first_rd, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_timer.md
Name: dm_timer

Overview:
- Memory-mapped timer peripheral. It is the responder on the CPU data-memory port: it uses the same CS / DM_R / DM_W / Addr / Data_In / Bit_S / Data_Out protocol that DMEM serves.
- Sits beside DMEM in the top level. The top level decodes the peripheral window from the CPU address and drives this block's CS.
- Provides a prescaled 32-bit up-counter, a compare register, a match flag and an interrupt line.

Parameters:
- ADDR_W, 11, width of Addr; same byte-offset width DMEM uses.
- PRESCALE_W, 16, width of the prescale register and the prescale counter.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- CS  input  1  block select from the top-level address decode.
- DM_R  input  1  read strobe; qualified by CS.
- DM_W  input  1  write strobe; qualified by CS; takes effect at the clock edge.
- Addr  input  ADDR_W  byte offset within the peripheral window.
- Data_In  input  32  write data, right-justified for sub-word writes.
- Bit_S  input  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- Data_Out  output  32  read data; combinational.
- irq  output  1  registered interrupt request.

Behaviour:
- Register map (word offsets, Addr[ADDR_W-1:2]):
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 PRESCALE[PRESCALE_W-1:0].
  - 0x08 COUNT.
  - 0x0C COMPARE.
  - 0x10 STATUS: bit0 MATCH; write-1-to-clear.
  - 0x14: see Optional Feature.
  - All other offsets read 0; writes to them are ignored.
- Reset: every register, the prescale counter and irq go to 0. Data_Out is 0 whenever CS & DM_R is low. Reset wins over any same-cycle bus write.
- Read path:
  - Combinational, zero latency, same as DMEM.
  - Halfword: Addr[1] selects the lane; the result is right-justified and zero-extended.
  - Byte: Addr[1:0] selects the lane; right-justified and zero-extended.
  - Sign extension is done by the CPU.
- Write path:
  - Byte-lane merge per Bit_S and Addr[1:0]; unselected lanes keep their old value.
  - Misaligned halfword (Addr[0]=1): Addr[0] is ignored.
- Prescale counter pcnt:
  - When EN=1, increments each cycle. When pcnt==PRESCALE, a tick is issued and pcnt returns to 0.
  - PRESCALE=0 therefore gives one tick per cycle.
- On a tick:
  - If COUNT==COMPARE: MATCH<=1, and COUNT<=0 when AUTO_RELOAD=1, else COUNT<=COUNT+1.
  - Otherwise: COUNT<=COUNT+1, wrapping 0xFFFFFFFF->0.
- EN=0: pcnt held at 0 and COUNT frozen. Writes to CTRL or PRESCALE clear pcnt.
- irq is a flop: irq <= MATCH & IRQ_EN, one cycle after the state change.
- Same-cycle conflicts:
  - Bus write to COUNT beats the tick update; no increment that cycle.
  - Hardware MATCH set beats a STATUS W1C clear.
  - Writing COMPARE while a tick occurs: the compare uses the old COMPARE.
- Write and read in the same cycle to the same register: Data_Out shows the old value.

Optional Feature:
- Macro DM_TIMER_CYCLE_EN.
- Defined: offset 0x14 is CYCLE, a read-only 32-bit free-running counter. It increments every clock regardless of EN, is cleared only by reset, and wraps. Writes to it are ignored.
- Undefined: 0x14 reads 0 and the counter logic is absent.

Decomposition:
- Package dm_timer_pkg holds:
  - register offset constants (TMR_CTRL..TMR_CYCLE);
  - CTRL bit indices;
  - Bit_S encodings (BS_WORD=2'b00, BS_HALF=2'b01, BS_BYTE=2'b10), shared with DMEM.
- One natural sub-module: dm_lane_merge, the combinational Bit_S/Addr byte-lane write merge and read extract. It is reusable by DMEM.

Test Plan:
- Reset then read every offset -> Data_Out=0, irq=0; unmapped offset 0x40 reads 0 after a write of 0xDEADBEEF.
- PRESCALE=0, COMPARE=5, CTRL=0x7 -> COUNT runs 0..5, MATCH set on the tick at COUNT==5, COUNT returns to 0, irq=1 one cycle later; STATUS write 0x1 -> MATCH=0, irq=0 next cycle.
- PRESCALE=3, EN only -> COUNT increments every 4 cycles; clear EN mid-count -> COUNT frozen and pcnt=0.
- Byte write 0xAB to 0x0E, then halfword write 0x1234 to 0x0C over COMPARE=0 -> COMPARE=0x00AB1234; byte read at 0x0E -> 0x000000AB.
- Write COUNT=0x100 on the same cycle as a tick -> COUNT=0x100, not 0x101; a MATCH set coinciding with a W1C leaves MATCH=1.
- With DM_TIMER_CYCLE_EN: two reads of 0x14 ten cycles apart differ by 10. Without it: 0x14 reads 0.
